// File: rtl/fetch_unit.sv
// fetch_unit: PC register and next-address select for the single-cycle MIPS core.
// Define FETCH_INSTRET_EN to build the retired-instruction counter; otherwise instret is tied to 0.
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          TAMANHO_MEMORIA = 64,
    parameter logic [31:0] HALT_WORD       = 32'h0000_000C
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr_in,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [31:0] rs_value,
    output logic [31:0] address,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instret
);

    localparam logic [31:0] ROM_BYTES = 32'(4 * TAMANHO_MEMORIA);

    typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

    state_t      state;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] target;
    logic        target_bad;
    logic        advance;

    assign pc_plus4  = address + 32'd4;
    assign br_target = pc_plus4 + {{14{instr_in[15]}}, instr_in[15:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], instr_in[25:0], 2'b00};

    // NOTE: default assignment first so no path through the block can infer a latch.
    always_comb begin
        target = pc_plus4;
        if (jump_reg)
            target = rs_value;
        else if (jump)
            target = j_target;
        else if (branch_taken)
            target = br_target;
    end

    // A PC+4 that wraps past 2^32 lands below the ROM only if the ROM spans the whole space,
    // so the unsigned range check also catches wrap-around.
    assign target_bad = (target[1:0] != 2'b00) || (target >= ROM_BYTES);
    assign advance    = (state == RUN) && !stall;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            address <= RESET_PC;
            halted  <= 1'b0;
            fault   <= 1'b0;
        end else if (advance) begin
            if (instr_in == HALT_WORD) begin
                state  <= HALT;
                halted <= 1'b1;
            end else if (target_bad) begin
                state <= FAULT;
                fault <= 1'b1;
            end else begin
                address <= target;
            end
        end
    end

`ifdef FETCH_INSTRET_EN
    logic [31:0] retired;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            retired <= 32'd0;
        else if (advance)
            retired <= retired + 32'd1;
    end

    assign instret = retired;
`else
    assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus for fetch_unit, checked against a behavioural model.
module tb_fetch_unit;

    localparam logic [31:0] HALT_W  = 32'h0000_000C;
    localparam int          ROM_LEN = 64;
    localparam int          M_RUN   = 0;
    localparam int          M_HALT  = 1;
    localparam int          M_FAULT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_in = 32'h0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jump = 1'b0;
    logic        jump_reg = 1'b0;
    logic [31:0] rs_value = 32'h0;
    logic [31:0] address;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        fault;
    logic [31:0] instret;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    int          m_mode;
    logic [31:0] m_cnt;

    fetch_unit #(
        .RESET_PC       (32'h0),
        .TAMANHO_MEMORIA(ROM_LEN),
        .HALT_WORD      (HALT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_in    (instr_in),
        .stall       (stall),
        .branch_taken(branch_taken),
        .jump        (jump),
        .jump_reg    (jump_reg),
        .rs_value    (rs_value),
        .address     (address),
        .pc_plus4    (pc_plus4),
        .halted      (halted),
        .fault       (fault),
        .instret     (instret)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_ret;
`ifdef FETCH_INSTRET_EN
        exp_ret = m_cnt;
`else
        exp_ret = 32'd0;
`endif
        check({tag, ".address"}, address, m_pc);
        check({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
        check({tag, ".halted"}, {31'd0, halted}, {31'd0, m_mode == M_HALT});
        check({tag, ".fault"}, {31'd0, fault}, {31'd0, m_mode == M_FAULT});
        check({tag, ".instret"}, instret, exp_ret);
    endtask

    // Asynchronous reset applied between clock edges; outputs must respond before any edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        m_pc   = 32'h0;
        m_mode = M_RUN;
        m_cnt  = 32'd0;
        #1;
        check_all(tag);
        #3;
        reset = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model per the fetch rules, then compare after the edge.
    task automatic apply(input string tag, input logic s, input logic br, input logic j,
                         input logic jr, input logic [31:0] rs, input logic [31:0] instr);
        longint t;
        stall = s; branch_taken = br; jump = j; jump_reg = jr; rs_value = rs; instr_in = instr;
        if (m_mode == M_RUN && !s) begin
            m_cnt = m_cnt + 32'd1;
            if (instr == HALT_W) begin
                m_mode = M_HALT;
            end else begin
                if (jr)
                    t = longint'(rs);
                else if (j)
                    t = ((longint'(m_pc) + 4) & 64'hF000_0000) | (longint'(instr[25:0]) * 4);
                else if (br)
                    t = longint'(m_pc) + 4 + longint'($signed(instr[15:0])) * 4;
                else
                    t = longint'(m_pc) + 4;
                t = t & 64'hFFFF_FFFF;
                if ((t % 4) != 0 || t >= 4 * ROM_LEN)
                    m_mode = M_FAULT;
                else
                    m_pc = t[31:0];
            end
        end
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic        r_s, r_br, r_j, r_jr;
        logic [31:0] r_rs, r_instr;
        logic [15:0] r_off;

        m_pc = 32'h0; m_mode = M_RUN; m_cnt = 32'd0;
        #12;
        check_all("reset");
        #1;
        reset = 1'b0;

        // Sequential fetch 0 -> 4 -> 8 -> 12
        apply("seq1", 0, 0, 0, 0, 0, 32'h2000_0001);
        apply("seq2", 0, 0, 0, 0, 0, 32'h2000_0002);
        apply("seq3", 0, 0, 0, 0, 0, 32'h2000_0003);
        // Backward branches, then jump overriding a branch
        apply("br_from12", 0, 1, 0, 0, 0, 32'h1000_FFFE);
        apply("br_from8", 0, 1, 0, 0, 0, 32'h1000_FFFE);
        apply("seq_to8", 0, 0, 0, 0, 0, 32'h2000_0004);
        apply("jump_over_br", 0, 1, 1, 0, 0, 32'h0800_0010);
        // Misaligned jr faults and freezes
        apply("jr_misalign", 0, 0, 1, 1, 32'h22, 32'h0800_0001);
        apply("fault_frozen", 0, 1, 1, 1, 32'h10, 32'h0000_0000);
        do_reset("reset_in_fault");
        // Range boundary: last word legal, one past faults, fall-through off the end faults
        apply("jr_last_word", 0, 0, 0, 1, 32'hFC, 32'h0);
        apply("fallthrough", 0, 0, 0, 0, 0, 32'h0);
        do_reset("reset2");
        apply("jr_oob", 0, 0, 0, 1, 32'h100, 32'h0);
        do_reset("reset3");
        // Stalled halt word is ignored; release edge halts
        apply("jr_to_20", 0, 1, 1, 1, 32'h20, 32'h0);
        apply("stall_halt1", 1, 0, 1, 0, 0, HALT_W);
        apply("stall_halt2", 1, 0, 0, 1, 32'h4, HALT_W);
        apply("halt_release", 0, 1, 1, 1, 32'h4, HALT_W);
        apply("halt_frozen1", 0, 0, 0, 1, 32'h8, 32'h0);
        apply("halt_frozen2", 0, 1, 0, 0, 0, 32'h1000_0004);
        do_reset("reset_in_halt");
        apply("resume", 0, 0, 0, 0, 0, 32'h2000_0005);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r_s   = ($urandom_range(0, 3) == 0);
            r_br  = ($urandom_range(0, 3) == 0);
            r_j   = ($urandom_range(0, 7) == 0);
            r_jr  = ($urandom_range(0, 7) == 0);
            r_rs  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 70)) * 32'd4
                    + (($urandom_range(0, 5) == 0) ? 32'd2 : 32'd0);
            r_off = 16'($signed($urandom_range(0, 40)) - 20);
            r_instr = {6'h04, 10'($urandom), r_off};
            if (r_j)
                r_instr[25:0] = 26'($urandom_range(0, 70));
            if ($urandom_range(0, 29) == 0)
                r_instr = HALT_W;
            apply("rand", r_s, r_br, r_j, r_jr, r_rs, r_instr);
            if (m_mode != M_RUN && $urandom_range(0, 2) == 0)
                do_reset("rand_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
